l2_cacheline_adaptor: RTL
=========================

Name: l2_cacheline_adaptor

Overview:
- Sits directly downstream of the L2 cache controller, between its physical-memory port and the burst-oriented main memory.
- Converts one 256-bit cacheline read or writeback request into a sequence of 64-bit memory beats.
- Assembles read beats into a full line and returns a single-cycle response to the L2.
- One outstanding transaction at a time; no buffering beyond one line.

Parameters:
LINE_WIDTH, 256, cacheline width in bits (L2 side)
BURST_WIDTH, 64, memory beat width in bits; LINE_WIDTH must be an integer multiple
ADDR_WIDTH, 32, byte address width
(derived) BEATS = LINE_WIDTH/BURST_WIDTH = 4; OFFSET_BITS = log2(LINE_WIDTH/8) = 5

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
line_i  input  LINE_WIDTH  writeback line from L2
line_o  output  LINE_WIDTH  assembled fill line to L2
address_i  input  ADDR_WIDTH  L2 request byte address
read_i  input  1  L2 line-fill request, level, held until resp_o
write_i  input  1  L2 writeback request, level, held until resp_o
resp_o  output  1  one-cycle completion pulse to L2
burst_i  input  BURST_WIDTH  read beat data from memory
burst_o  output  BURST_WIDTH  write beat data to memory
address_o  output  ADDR_WIDTH  line-aligned memory address
read_o  output  1  memory read request
write_o  output  1  memory write request
resp_i  input  1  memory beat acknowledge, one per beat

Behaviour:
- Reset (reset_n=0 at posedge): state=IDLE, beat counter=0, line buffer=0, address register=0. All outputs are 0.
- Reset mid-burst aborts the transaction with no resp_o. The memory side sees read_o/write_o drop the next cycle.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - write_i=1: latch line_i into the line buffer and address_i into the address register, then go to WRITE. Write has priority if write_i and read_i are both 1.
  - read_i=1 and write_i=0: latch address_i, go to READ.
  - Counter is cleared on entry to READ/WRITE.
- address_o = latched address with bits [OFFSET_BITS-1:0] forced to 0; stable for the whole transaction.
- READ:
  - read_o=1 every cycle.
  - Each cycle with resp_i=1: write burst_i into slice [cnt*BURST_WIDTH +: BURST_WIDTH] of the buffer, then increment cnt.
  - Beats may be back-to-back or separated by idle cycles with resp_i=0.
  - On the beat where cnt==BEATS-1: go to DONE. read_o is 0 from the next cycle.
- WRITE:
  - write_o=1; burst_o = buffer slice [cnt*BURST_WIDTH +: BURST_WIDTH], combinational from cnt.
  - Each resp_i=1 advances cnt.
  - Last beat: go to DONE.
- DONE:
  - resp_o=1 for exactly this one cycle.
  - read_i/write_i are ignored in this cycle, because the L2 may already present its next request here (writeback immediately followed by fill).
  - Next state is IDLE unconditionally. IDLE samples the still-held request one cycle later.
- line_o = line buffer, continuously. It is valid in DONE after a read and holds until the next read beat overwrites it.
  - A write transaction loads line_i into the buffer, so after a write line_o shows the written line.
- Fill latency with back-to-back beats, request to resp_o: 1 (IDLE) + BEATS (READ) + 1 (DONE) = 6 cycles.
- Boundary conditions:
  - resp_i in IDLE/DONE is ignored.
  - cnt wraps only via the DONE→IDLE path, never mid-transaction.
  - read_i/write_i changes during READ/WRITE are ignored.
  - Unaligned address_i is accepted and aligned.
  - An undefined state triggers $fatal in simulation.

Test Plan:
- Read, consecutive beats: reset, read_i=1, address_i=0x0000_1234; memory returns resp_i for 4 cycles with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> address_o=0x0000_1220; read_o high for exactly 4 cycles; resp_o pulses once, 6 cycles after the request; line_o = {0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- Read with gaps: same read, with resp_i low for 2 cycles between beats 1 and 2 -> identical line_o; resp_o is delayed by 2 cycles; read_o stays high through the gap.
- Writeback: write_i=1, line_i = {D3,D2,D1,D0}, address 0x8000_0040 -> write_o high, burst_o = D0, D1, D2, D3 in acknowledge order; resp_o pulses once; write_o drops after the 4th resp_i.
- Writeback then fill, L2-style: write_i completes and read_i is raised in the DONE cycle -> the read is not started in DONE; READ is entered one cycle after IDLE; exactly one resp_o per transaction.
- Simultaneous request: read_i=1 and write_i=1 in IDLE -> write_o asserted, read_o stays 0 until the write's resp_o.
- Reset mid-burst: reset_n=0 after 2 read beats -> next cycle read_o=0, resp_o=0, line_o=0; a subsequent full read completes normally with a correct line.

Source files
------------

// File: rtl/l2_cacheline_adaptor_if.sv
// Bus bundle between the L2 physical-memory port, the cacheline adaptor and burst main memory.
// The adaptor uses the slave view; the L2/memory environment uses the master view.
interface l2_cacheline_adaptor_if #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
);
  // L2 side
  logic [LINE_WIDTH-1:0]  line_i;
  logic [LINE_WIDTH-1:0]  line_o;
  logic [ADDR_WIDTH-1:0]  address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  // Memory side
  logic [BURST_WIDTH-1:0] burst_i;
  logic [BURST_WIDTH-1:0] burst_o;
  logic [ADDR_WIDTH-1:0]  address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/l2_cacheline_adaptor.sv
// Splits one L2 cacheline read/writeback into BEATS memory bursts and reassembles fills.
// One transaction in flight; the single line buffer serves both directions.
module l2_cacheline_adaptor #(
  parameter int LINE_WIDTH  = 256,
  parameter int BURST_WIDTH = 64,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  l2_cacheline_adaptor_if.slave   bus
);
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;
  localparam int OFFSET_BITS = $clog2(LINE_WIDTH / 8);
  localparam int CNT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                state;
  state_t                next_state;
  logic [CNT_W-1:0]      cnt;
  logic [LINE_WIDTH-1:0] line_buf;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  last_beat;

  assign last_beat = bus.resp_i && (cnt == LAST_BEAT);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: every output of this block is defaulted first, so no path leaves a latch behind.
  always_comb begin
    next_state  = state;
    bus.read_o  = 1'b0;
    bus.write_o = 1'b0;
    bus.resp_o  = 1'b0;
    bus.burst_o = '0;
    case (state)
      IDLE: begin
        // Writeback wins when both requests are raised together.
        if (bus.write_i)     next_state = WRITE;
        else if (bus.read_i) next_state = READ;
      end
      READ: begin
        bus.read_o = 1'b1;
        if (last_beat) next_state = DONE;
      end
      WRITE: begin
        bus.write_o = 1'b1;
        bus.burst_o = line_buf[int'(cnt) * BURST_WIDTH +: BURST_WIDTH];
        if (last_beat) next_state = DONE;
      end
      DONE: begin
        // Requests are deliberately not sampled here; the L2 may already show its next one.
        bus.resp_o = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the line buffer is reset on purpose, because line_o must read zero out of reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt      <= '0;
      line_buf <= '0;
      addr_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.write_i) begin
            line_buf <= bus.line_i;
            addr_q   <= bus.address_i;
            cnt      <= '0;
          end else if (bus.read_i) begin
            addr_q   <= bus.address_i;
            cnt      <= '0;
          end
        end
        READ: begin
          if (bus.resp_i) begin
            line_buf[int'(cnt) * BURST_WIDTH +: BURST_WIDTH] <= bus.burst_i;
            cnt <= cnt + 1'b1;
          end
        end
        WRITE: begin
          if (bus.resp_i) cnt <= cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.address_o = {addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign bus.line_o    = line_buf;

  // An X/undefined state means something upstream is broken; stop the simulation loudly.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (!$isunknown(state))
        else $fatal(1, "l2_cacheline_adaptor: undefined state");
    end
  end
endmodule
